// File: rtl/ex_mem_queue.sv
// EX/MEM pipeline buffer: DEPTH-entry in-order queue with valid/ready
// handshake, global flush and per-hart selective kill.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_flush               kill every entry and the incoming beat
//   i_flush_hart          bit h kills entries / incoming beat of hart h
//   i_in_valid/o_in_ready EX side handshake; i_in_payload, i_in_hart_id
//   o_out_valid/i_out_ready MEM side handshake; o_out_payload, o_out_hart_id
//   o_occupancy           entries held, live or killed
module ex_mem_queue #(
    parameter int PAYLOAD_W = 110,
    parameter int HART_ID_W = 2,
    parameter int NUM_HARTS = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic [NUM_HARTS-1:0] i_flush_hart,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [PAYLOAD_W-1:0] i_in_payload,
    input  logic [HART_ID_W-1:0] i_in_hart_id,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [PAYLOAD_W-1:0] o_out_payload,
    output logic [HART_ID_W-1:0] o_out_hart_id,
    output logic [CNT_W-1:0]     o_occupancy
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] r_payload [DEPTH];
    logic [HART_ID_W-1:0] r_hart    [DEPTH];
    logic [DEPTH-1:0]     r_live;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic                 w_nonempty;
    logic [HART_ID_W-1:0] w_head_hart;
    logic                 w_head_kill;
    logic                 w_push;
    logic                 w_pop;

    assign w_nonempty  = (r_count != '0);
    assign w_head_hart = r_hart[r_rd_ptr];
    assign w_head_kill = i_flush | i_flush_hart[w_head_hart];

    // in_ready looks only at registered occupancy: no in->out comb path
    assign o_in_ready  = (r_count < CNT_W'(DEPTH));
    assign o_out_valid = w_nonempty & r_live[r_rd_ptr] & ~w_head_kill;

    assign o_out_payload = o_out_valid ? r_payload[r_rd_ptr] : '0;
    assign o_out_hart_id = o_out_valid ? w_head_hart : '0;
    assign o_occupancy   = r_count;

    assign w_push = i_in_valid & o_in_ready & ~i_flush
                  & ~i_flush_hart[i_in_hart_id];

    // Dead heads (killed earlier or this cycle) drain without out_valid
    assign w_pop = w_nonempty
                 & ((o_out_valid & i_out_ready)
                    | ~r_live[r_rd_ptr] | w_head_kill);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_payload[i] <= '0;
                r_hart[i]    <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_live   <= '0;
        end else begin
            // Kill, then retire the head, then write: the pushed hart is
            // never flushed this cycle, and wr_ptr never equals a popped
            // rd_ptr unless the queue was empty (no pop).
            for (int i = 0; i < DEPTH; i++) begin
                if (i_flush_hart[r_hart[i]])
                    r_live[i] <= 1'b0;
            end
            if (w_pop) begin
                r_live[r_rd_ptr] <= 1'b0;
                r_rd_ptr         <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_payload[r_wr_ptr] <= i_in_payload;
                r_hart[r_wr_ptr]    <= i_in_hart_id;
                r_live[r_wr_ptr]    <= 1'b1;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: doc/ex_mem_queue.md
Name: ex_mem_queue

Overview:
- Parametrised EX/MEM pipeline buffer for the multithreaded core. Replaces the single-entry EX stage register with a DEPTH-entry in-order queue.
- Uses a valid/ready handshake instead of a global stall, so a stalled MEM stage no longer freezes EX.
- Supports per-hart selective flush: a trapping or redirecting hart kills only its own in-flight entries. Other harts keep flowing.
- Sits between the EX stage (writer) and the MEM stage (reader). The payload is an opaque packed bundle: exp_code, pc, en, mem_op, wr_data, rd_addr, gpr_we_, ex_out.

Parameters:
- PAYLOAD_W, 110: width of the packed EX/MEM bundle.
- HART_ID_W, 2: hart id width.
- NUM_HARTS, 4: number of harts; equals 2**HART_ID_W.
- DEPTH, 4: queue entries; power of two, at least 2.
- CNT_W, 3: occupancy width; equals clog2(DEPTH+1).

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- flush, input, 1: global flush; kills every entry and the incoming beat.
- flush_hart, input, NUM_HARTS: bit h kills all entries and any incoming beat of hart h.
- in_valid, input, 1: EX presents a beat.
- in_ready, output, 1: queue can accept a beat.
- in_payload, input, PAYLOAD_W: EX bundle.
- in_hart_id, input, HART_ID_W: hart owning the incoming beat.
- out_valid, output, 1: a live head entry is presented to MEM.
- out_ready, input, 1: MEM accepts the head.
- out_payload, output, PAYLOAD_W: head bundle; all zero when out_valid=0.
- out_hart_id, output, HART_ID_W: head hart id; zero when out_valid=0.
- occupancy, output, CNT_W: entries held, live or killed.

Behaviour:
- Reset:
  - Registered state: count=0, wr_ptr=0, rd_ptr=0, all live bits 0, all storage 0.
  - Resulting outputs: out_valid=0, out_payload=0, out_hart_id=0, in_ready=1, occupancy=0.
  - reset has priority over flush and all other inputs.
- Storage:
  - Circular buffer of DEPTH entries {payload, hart_id, live}.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap naturally.
  - count is held separately to distinguish full from empty.
- in_ready = (count < DEPTH). It depends on registered count only and never on out_ready, so there is no combinational in->out path.
- head_kill = flush | flush_hart[hart_id[rd_ptr]].
- out_valid = (count != 0) & live[rd_ptr] & ~head_kill.
  - A beat being flushed this cycle is never offered to MEM.
  - out_payload and out_hart_id are gated to zero when out_valid=0.
- Push:
  - Condition: push = in_valid & in_ready & ~flush & ~flush_hart[in_hart_id].
  - Writes the entry at wr_ptr with live=1; wr_ptr increments.
  - A suppressed beat is dropped silently; EX sees in_ready as normal.
- Pop:
  - Condition: pop = (count != 0) & ((out_valid & out_ready) | ~live[rd_ptr] | head_kill); rd_ptr increments.
  - Killed entries drain from the head automatically, one per cycle, without asserting out_valid.
- Kill: each cycle, every held entry i with flush_hart[hart_id[i]]=1 has its live bit cleared. The entry stays in place until it drains.
- count_next = count + push - pop. Push and pop in the same cycle are legal at any occupancy below DEPTH, including count=1.
- When full, in_ready=0 and no push occurs, even if a pop happens that cycle.
- Global flush (flush=1, reset=0): next cycle count=0, wr_ptr=rd_ptr=0, all live=0. No push; out_valid=0 in the flush cycle.
- Simultaneous flush_hart and push of another hart: the push proceeds.
- Latency: a pushed beat can appear on out_valid no earlier than the next cycle (1-cycle minimum), matching the old register.
- Ordering: strict in-order across harts. Order is preserved across pointer wrap.

Test Plan:
1. Reset asserted for 2 cycles with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0, out_payload=0.
2. DEPTH=4, out_ready=0; push A(h0), B(h1), C(h2), D(h3), then E -> occupancy=4, in_ready=0, E dropped. Then out_ready=1 -> A, B, C, D on 4 consecutive cycles; occupancy returns to 0.
3. Queue A(h0), B(h1), C(h0); pulse flush_hart=4'b0001 one cycle, out_ready=1 -> MEM receives only B. A and C drain without out_valid; occupancy=0 within 3 cycles.
4. occupancy=1, in_valid=1 and out_ready=1 same cycle -> occupancy stays 1, the new beat is presented next cycle, the old beat is accepted.
5. occupancy=3, flush=1 with in_valid=1 -> out_valid=0 that cycle; next cycle occupancy=0, in_ready=1, incoming beat absent.
6. Stream 20 beats with payload=index through DEPTH=4, random out_ready, harts round-robin -> outputs 0..19 in order. Pointers wrap at least 4 times; no beat lost or duplicated.
